// File: rtl/oc8051_psw_if.sv
// PSW unit bus: SFR byte/bit write ports, ALU flag write-back and the
// read-side outputs (PSW byte, carry to carry-select, register bank).
interface oc8051_psw_if;
  logic       wr;
  logic [7:0] wr_addr;
  logic [7:0] data_in;
  logic       wr_bit;
  logic [7:0] bit_addr;
  logic       bit_in;
  logic [1:0] flag_set;
  logic       cy_new;
  logic       ac_new;
  logic       ov_new;
  logic [7:0] acc;
  logic [7:0] data_out;
  logic       cy_out;
  logic [1:0] bank_sel;

  modport master (
    output wr, wr_addr, data_in, wr_bit, bit_addr, bit_in,
           flag_set, cy_new, ac_new, ov_new, acc,
    input  data_out, cy_out, bank_sel
  );

  modport slave (
    input  wr, wr_addr, data_in, wr_bit, bit_addr, bit_in,
           flag_set, cy_new, ac_new, ov_new, acc,
    output data_out, cy_out, bank_sel
  );
endinterface

// File: rtl/oc8051_psw_unit.sv
// oc8051 program status word. Stores CY,AC,F0,RS1,RS0,OV,F1 (bits 7..1);
// parity P (bit 0) is derived from the accumulator and never stored.
// Update priority: SFR byte write, then ALU flag update merged with an SFR
// bit write, where the bit write wins on a colliding field.
module oc8051_psw_unit #(
  parameter logic [7:0] PSW_ADDR = 8'hD0,
  parameter bit         FWD_CY   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  oc8051_psw_if.slave     bus
);

  logic [7:1] psw_p0;
  logic [7:1] psw_nxt;
  logic       byte_hit;
  logic       bit_hit;
  logic       unused_data_lsb;

  assign byte_hit = bus.wr && (bus.wr_addr == PSW_ADDR);
  assign bit_hit  = bus.wr_bit && (bus.bit_addr[7:3] == PSW_ADDR[7:3]) && !byte_hit;

  // The P position of a byte write has no flop behind it.
  assign unused_data_lsb = bus.data_in[0];

  // Next-state PSW: byte write overrides everything; otherwise flags from the
  // ALU are applied first and a bit write then overrides its single bit.
  always_comb begin
    psw_nxt = psw_p0;
    if (byte_hit) begin
      psw_nxt = bus.data_in[7:1];
    end else begin
      case (bus.flag_set)
        2'b01: psw_nxt[7] = bus.cy_new;
        2'b10: begin
          psw_nxt[7] = bus.cy_new;
          psw_nxt[6] = bus.ac_new;
          psw_nxt[2] = bus.ov_new;
        end
        2'b11: begin
          psw_nxt[7] = bus.cy_new;
          psw_nxt[2] = bus.ov_new;
        end
        default: ;
      endcase
      if (bit_hit) begin
        for (int i = 1; i < 8; i++) begin
          if (bus.bit_addr[2:0] == 3'(i)) psw_nxt[i] = bus.bit_in;
        end
      end
    end
  end

  // ---- stage p0: PSW flag register ----
  // State register; asserted reset clears every flag and drops any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) psw_p0 <= '0;
    else      psw_p0 <= psw_nxt;
  end

  assign bus.data_out = {psw_p0, ^bus.acc};
  assign bus.bank_sel = psw_p0[4:3];

  // Carry bypass lets a back-to-back carry consumer see the carry being
  // written this cycle; it is forced low while reset is held.
  generate
    if (FWD_CY) begin : g_cy_fwd
      assign bus.cy_out = rst & psw_nxt[7];
    end else begin : g_cy_reg
      assign bus.cy_out = psw_p0[7];
    end
  endgenerate

endmodule

// File: tb/tb_oc8051_psw_unit.sv
// Bench for oc8051_psw_unit: a bypassing and a registered-carry instance
// share one stimulus stream and are compared with a flag-level model.
module tb_oc8051_psw_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wr_addr;
  logic [7:0] data_in;
  logic       wr_bit;
  logic [7:0] bit_addr;
  logic       bit_in;
  logic [1:0] flag_set;
  logic       cy_new, ac_new, ov_new;
  logic [7:0] acc;

  // Model: one entry per PSW bit position (index 0 unused, P is computed)
  logic [7:0] mdl;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  oc8051_psw_if bus_f ();
  oc8051_psw_if bus_r ();

  assign bus_f.wr = wr;             assign bus_r.wr = wr;
  assign bus_f.wr_addr = wr_addr;   assign bus_r.wr_addr = wr_addr;
  assign bus_f.data_in = data_in;   assign bus_r.data_in = data_in;
  assign bus_f.wr_bit = wr_bit;     assign bus_r.wr_bit = wr_bit;
  assign bus_f.bit_addr = bit_addr; assign bus_r.bit_addr = bit_addr;
  assign bus_f.bit_in = bit_in;     assign bus_r.bit_in = bit_in;
  assign bus_f.flag_set = flag_set; assign bus_r.flag_set = flag_set;
  assign bus_f.cy_new = cy_new;     assign bus_r.cy_new = cy_new;
  assign bus_f.ac_new = ac_new;     assign bus_r.ac_new = ac_new;
  assign bus_f.ov_new = ov_new;     assign bus_r.ov_new = ov_new;
  assign bus_f.acc = acc;           assign bus_r.acc = acc;

  oc8051_psw_unit #(.PSW_ADDR(8'hD0), .FWD_CY(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .bus(bus_f)
  );
  oc8051_psw_unit #(.PSW_ADDR(8'hD0), .FWD_CY(1'b0)) u_reg (
    .clk(clk), .rst(rst), .bus(bus_r)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    wr = 0; wr_addr = 0; data_in = 0; wr_bit = 0; bit_addr = 0; bit_in = 0;
    flag_set = 0; cy_new = 0; ac_new = 0; ov_new = 0;
  endtask

  // Flag-level next state from the current inputs
  function automatic logic [7:0] next_model();
    logic [7:0] n;
    n = mdl;
    if (wr && wr_addr == 8'hD0) begin
      n = {data_in[7:1], 1'b0};
    end else begin
      if (flag_set != 2'b00) n[7] = cy_new;             // CY
      if (flag_set == 2'b10) n[6] = ac_new;             // AC
      if (flag_set == 2'b10 || flag_set == 2'b11) n[2] = ov_new; // OV
      if (wr_bit && bit_addr >= 8'hD1 && bit_addr <= 8'hD7)
        n[bit_addr - 8'hD0] = bit_in;
    end
    return n;
  endfunction

  // Inputs already applied at the falling edge; check, clock, advance model
  task automatic cycle();
    logic [7:0] nx;
    nx = next_model();
    #1;
    chk("dout_fwd", bus_f.data_out, {mdl[7:1], ^acc});
    chk("dout_reg", bus_r.data_out, {mdl[7:1], ^acc});
    chk("bank_sel", {6'b0, bus_f.bank_sel}, {6'b0, mdl[4:3]});
    chk("cy_fwd", {7'b0, bus_f.cy_out}, {7'b0, nx[7]});
    chk("cy_reg", {7'b0, bus_r.cy_out}, {7'b0, mdl[7]});
    @(posedge clk);
    mdl = nx;
    @(negedge clk);
  endtask

  task automatic byte_wr(input logic [7:0] d);
    idle(); wr = 1; wr_addr = 8'hD0; data_in = d; cycle();
  endtask

  initial begin
    idle();
    acc = 8'h07;
    rst = 1'b0;
    mdl = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dout", bus_f.data_out, 8'h01);
    chk("rst_bank", {6'b0, bus_f.bank_sel}, 8'h00);
    chk("rst_cy_fwd", {7'b0, bus_f.cy_out}, 8'h00);
    chk("rst_cy_reg", {7'b0, bus_r.cy_out}, 8'h00);
    wr = 1; wr_addr = 8'hD0; data_in = 8'hFF;
    #1;
    chk("rst_cy_fwd_wr", {7'b0, bus_f.cy_out}, 8'h00);
    @(negedge clk);
    idle(); rst = 1'b1;
    #1 chk("rst_rel", bus_f.data_out, 8'h01);
    @(negedge clk);

    // Reset asserted during a byte write discards the write
    wr = 1; wr_addr = 8'hD0; data_in = 8'hFF;
    #2 rst = 1'b0;
    #1 chk("midrst_dout", bus_f.data_out, 8'h01);
    @(posedge clk);
    @(negedge clk);
    idle(); rst = 1'b1;
    #1 chk("midrst_after", bus_r.data_out, 8'h01);
    @(negedge clk);

    // Byte write to the PSW, then to a neighbouring address
    acc = 8'h00;
    byte_wr(8'hFF);
    idle(); #1;
    chk("bytewr", bus_f.data_out, 8'hFE);
    chk("bytewr_bank", {6'b0, bus_f.bank_sel}, 8'h03);
    wr = 1; wr_addr = 8'hD1; data_in = 8'h00; cycle();
    idle(); #1 chk("bytewr_other", bus_f.data_out, 8'hFE);

    // ALU flag updates
    byte_wr(8'h00);
    idle(); flag_set = 2'b10; cy_new = 1; ac_new = 0; ov_new = 1; cycle();
    idle(); #1 chk("flag10", bus_f.data_out, 8'h84);
    flag_set = 2'b01; cy_new = 0; cycle();
    idle(); #1 chk("flag01", bus_f.data_out, 8'h04);

    // Bit write merged with a flag update, bit write wins on CY
    byte_wr(8'h00);
    idle(); flag_set = 2'b10; cy_new = 1; ac_new = 1; ov_new = 1;
    wr_bit = 1; bit_addr = 8'hD7; bit_in = 0; cycle();
    idle(); #1 chk("merge", bus_f.data_out, 8'h44);
    flag_set = 2'b10; cy_new = 1; ac_new = 1; ov_new = 1;
    wr_bit = 1; bit_addr = 8'hD7; bit_in = 0;
    wr = 1; wr_addr = 8'hD0; data_in = 8'h18; cycle();
    idle(); #1 chk("byte_prio", bus_f.data_out, 8'h18);

    // Carry bypass vs registered carry
    byte_wr(8'h00);
    idle(); flag_set = 2'b01; cy_new = 1;
    #1;
    chk("fwd_same", {7'b0, bus_f.cy_out}, 8'h01);
    chk("reg_same", {7'b0, bus_r.cy_out}, 8'h00);
    cycle();
    idle(); #1 chk("reg_next", {7'b0, bus_r.cy_out}, 8'h01);

    // Bit write to the P position is ignored
    wr_bit = 1; bit_addr = 8'hD0; bit_in = 1; acc = 8'h03; cycle();
    idle(); #1 chk("pbit", bus_f.data_out, 8'h80);

    // Randomized traffic, with occasional asynchronous reset pulses
    for (int k = 0; k < 400; k++) begin
      idle();
      acc      = 8'($urandom);
      wr       = ($urandom_range(0, 3) == 0);
      wr_addr  = $urandom_range(0, 1) ? 8'hD0 : 8'($urandom);
      data_in  = 8'($urandom);
      wr_bit   = ($urandom_range(0, 1) == 0);
      bit_addr = ($urandom_range(0, 3) != 0) ? {5'h1A, 3'($urandom)} : 8'($urandom);
      bit_in   = 1'($urandom);
      flag_set = 2'($urandom);
      cy_new   = 1'($urandom);
      ac_new   = 1'($urandom);
      ov_new   = 1'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        #2 rst = 1'b0;
        #1;
        chk("rnd_rst_dout", bus_f.data_out, {7'b0, ^acc});
        chk("rnd_rst_cy", {7'b0, bus_f.cy_out}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mdl = '0;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oc8051_psw_unit.md
Name: oc8051_psw_unit

Overview:
- Program status word register for the oc8051 core.
- Holds CY, AC, F0, RS1, RS0, OV and F1. Derives P from the accumulator.
- Drives the carry input of the carry-select stage and the register-bank select.
- Accepts three kinds of update: SFR byte writes, SFR bit writes, and flag updates from the ALU write-back.
- Optionally forwards the carry being written in the current cycle, so a back-to-back carry consumer sees it without a stall.

Parameters:
- PSW_ADDR, 8'hD0: direct SFR byte address of the PSW. Bit addresses are PSW_ADDR+0 .. PSW_ADDR+7.
- FWD_CY, 1: 1 = cy_out carries the next-state CY combinationally (bypass); 0 = cy_out is the registered CY.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- wr  in  1  SFR byte write strobe
- wr_addr  in  8  SFR byte write address
- data_in  in  8  SFR byte write data
- wr_bit  in  1  SFR bit write strobe
- bit_addr  in  8  bit write address
- bit_in  in  1  bit write data
- flag_set  in  2  flag update select from decoder: 00 none, 01 CY, 10 CY+AC+OV, 11 CY+OV
- cy_new  in  1  ALU carry result
- ac_new  in  1  ALU auxiliary carry result
- ov_new  in  1  ALU overflow result
- acc  in  8  current accumulator value
- data_out  out  8  PSW read value {CY,AC,F0,RS1,RS0,OV,F1,P}
- cy_out  out  1  carry to the carry-select stage
- bank_sel  out  2  register bank {RS1,RS0} to the RAM address stage

Behaviour:
- State: seven flops, one each for CY, AC, F0, RS1, RS0, OV and F1.
- P is not stored. data_out[0] = XOR reduction of acc, combinational, valid in and out of reset.
- Reset (rst=0, asynchronous): all seven flops cleared to 0.
  - data_out = {7'b0, ^acc}.
  - bank_sel = 2'b00.
  - cy_out = 0.
- Reset is released synchronously in effect: the first update is taken at the first rising edge with rst=1.
- Reset mid-update: the asserted reset wins immediately and the pending write is lost.
- Byte write (wr=1 and wr_addr==PSW_ADDR): at the next edge, flops take data_in[7:1]. data_in[0] is ignored.
  - Highest priority: a same-cycle bit write or flag_set is discarded entirely.
  - wr with any other address has no effect.
- Bit write (wr_bit=1, bit_addr[7:3]==PSW_ADDR[7:3], and no byte write): the bit selected by bit_addr[2:0] takes bit_in.
  - bit_addr[2:0]==0 (P) is ignored.
- Flag update (flag_set!=00, no byte write):
  - 01: CY <= cy_new.
  - 10: CY <= cy_new, AC <= ac_new, OV <= ov_new.
  - 11: CY <= cy_new, OV <= ov_new.
  - Bits not selected hold their value.
- Simultaneous bit write and flag update:
  - Fields are merged.
  - On a collision (the bit write targets CY, AC or OV while flag_set also updates that field), the bit write wins for that bit only.
- Read latency:
  - Register updates appear on data_out and bank_sel one cycle after the strobe.
  - P follows acc with zero latency.
- cy_out:
  - FWD_CY=0: cy_out = registered CY.
  - FWD_CY=1: cy_out = the value CY will take at the next edge under the priority rules above. When no CY update is active, that is the registered CY.
  - FWD_CY=1 creates a combinational path from wr/wr_bit/flag_set/cy_new/data_in/bit_in to cy_out. Integration must close timing on it.
- Reads of data_out are unaffected by same-cycle writes: data_out[7:1] is always the registered value, including when FWD_CY=1.

Test Plan:
- Reset then acc=8'h07 -> data_out=8'h01, bank_sel=0, cy_out=0. Assert rst mid-byte-write -> flops stay 0.
- wr=1, wr_addr=8'hD0, data_in=8'hFF, acc=8'h00 -> next cycle data_out=8'hFE, bank_sel=2'b11. Repeat with wr_addr=8'hD1 -> no change.
- flag_set=10, cy_new=1, ac_new=0, ov_new=1 from 0 -> data_out=8'h84. Next flag_set=01, cy_new=0 -> 8'h04.
- Same cycle: flag_set=10 (cy_new=1, ac_new=1, ov_new=1) with wr_bit to 8'hD7, bit_in=0 -> CY=0, AC=1, OV=1, data_out=8'h44. Add wr to PSW with data_in=8'h18 -> data_out=8'h18 only.
- FWD_CY=1, CY=0, flag_set=01, cy_new=1 -> cy_out=1 in the same cycle. FWD_CY=0 -> cy_out=1 one cycle later.
- Bit write to 8'hD0 with bit_in=1, acc=8'h03 -> data_out[0] stays 0, no flop changes.
